// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix transposer and its serial sequencer.
// Holds element geometry, size codes, the FSM state type and the slot index helper.
package matrix_pkg;

    localparam int DATA_W = 8;
    localparam int MAX_N  = 5;
    localparam int MAT_W  = MAX_N * MAX_N * DATA_W;

    localparam logic [1:0] SZ_2X2 = 2'b00;
    localparam logic [1:0] SZ_3X3 = 2'b01;
    localparam logic [1:0] SZ_4X4 = 2'b10;
    localparam logic [1:0] SZ_5X5 = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        SEND
    } state_t;

    // Slot of element (r,c) in the packed matrix; the row pitch is always MAX_N.
    function automatic logic [4:0] elem_idx(input logic [2:0] r, input logic [2:0] c);
        return ({2'b00, r} * 5'd5) + {2'b00, c};
    endfunction

    function automatic logic [2:0] order_of(input logic [1:0] size_code);
        logic [2:0] n;
        case (size_code)
            SZ_2X2:  n = 3'd2;
            SZ_3X3:  n = 3'd3;
            SZ_4X4:  n = 3'd4;
            SZ_5X5:  n = 3'd5;
            default: n = 3'd2;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/transposicao_matriz.sv
// Combinational transposer for a packed square matrix of order 2..5.
// Slots outside the active N x N window are driven to zero.
module transposicao_matriz
    import matrix_pkg::*;
(
    input  logic [MAT_W-1:0] matrix_A,
    input  logic [1:0]       matrix_size,
    output logic [MAT_W-1:0] m_transposta_A
);

    always_comb begin
        int n;
        m_transposta_A = '0;
        n = int'(order_of(matrix_size));
        for (int r = 0; r < MAX_N; r++) begin
            for (int c = 0; c < MAX_N; c++) begin
                if (r < n && c < n) begin
                    m_transposta_A[(r*MAX_N + c)*DATA_W +: DATA_W] =
                        matrix_A[(c*MAX_N + r)*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/controlador_transposicao.sv
// Serial front end for transposicao_matriz: loads a matrix element by element,
// transposes it in one cycle and streams the result back out, row-major.
module controlador_transposicao
    import matrix_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int MAX_N  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        matrix_size,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int MAT_BITS = MAX_N * MAX_N * DATA_W;

    state_t              state_q, state_d;
    logic [1:0]          size_q, size_d;
    logic [2:0]          row_q, row_d;
    logic [2:0]          col_q, col_d;
    logic [MAT_BITS-1:0] mat_q, mat_d;
    logic [MAT_BITS-1:0] res_q, res_d;
    logic                done_q, done_d;

    logic [MAT_BITS-1:0] trans_out;
    logic [2:0]          last_idx;
    logic                at_last;

    transposicao_matriz u_transp (
        .matrix_A       (mat_q),
        .matrix_size    (size_q),
        .m_transposta_A (trans_out)
    );

    assign last_idx = order_of(size_q) - 3'd1;
    assign at_last  = (row_q == last_idx) && (col_q == last_idx);

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        row_d   = row_q;
        col_d   = col_q;
        mat_d   = mat_q;
        res_d   = res_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mat_d   = '0;
                    size_d  = matrix_size;
                    row_d   = 3'd0;
                    col_d   = 3'd0;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                if (in_valid) begin
                    mat_d[elem_idx(row_q, col_q)*DATA_W +: DATA_W] = in_data;
                    if (at_last) begin
                        row_d   = 3'd0;
                        col_d   = 3'd0;
                        state_d = CALC;
                    end else if (col_q == last_idx) begin
                        col_d = 3'd0;
                        row_d = row_q + 3'd1;
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
            end

            CALC: begin
                res_d   = trans_out;
                row_d   = 3'd0;
                col_d   = 3'd0;
                state_d = SEND;
            end

            SEND: begin
                if (out_ready) begin
                    // Counters return to (0,0) on the final element so the read index stays in range.
                    if (at_last) begin
                        row_d   = 3'd0;
                        col_d   = 3'd0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (col_q == last_idx) begin
                        col_d = 3'd0;
                        row_d = row_q + 3'd1;
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            size_q  <= 2'b00;
            row_q   <= 3'd0;
            col_q   <= 3'd0;
            mat_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            row_q   <= row_d;
            col_q   <= col_d;
            mat_q   <= mat_d;
            res_q   <= res_d;
            done_q  <= done_d;
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == SEND);
    assign out_last  = (state_q == SEND) && at_last;
    assign out_data  = res_q[elem_idx(row_q, col_q)*DATA_W +: DATA_W];
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_controlador_transposicao.sv
// Scoreboard bench for controlador_transposicao: expected transposed streams are queued
// when a matrix is loaded and popped as output handshakes occur.
module tb_controlador_transposicao;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] matrix_size = 2'b00;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic       out_last;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] stim[25];

    controlador_transposicao dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .matrix_size (matrix_size),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Loads `limit` elements of stim[] (row-major); queues the transposed stream when complete.
    task automatic load_matrix(input int n, input bit issue_start, input int gap_pct, input int limit);
        int k = 0;
        int budget = 0;
        bit hs;
        if (issue_start) begin
            @(negedge clk);
            start = 1'b1;
            matrix_size = 2'(n - 2);
            @(negedge clk);
            start = 1'b0;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL load_entry: in_ready=%b required 1", in_ready);
            end
        end
        while (k < limit && budget < 500) begin
            budget++;
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = stim[k];
            end
            hs = in_valid && in_ready;
            @(posedge clk);
            if (hs) k++;
            #1;
            in_valid = 1'b0;
            if (k < limit) @(negedge clk);
        end
        n_checks++;
        if (k != limit) begin
            n_fail++;
            $display("FAIL load_timeout: accepted %0d required %0d", k, limit);
        end
        if (limit == n * n) begin
            for (int i = 0; i < n * n; i++) begin
                exp_q.push_back(stim[(i % n) * n + (i / n)]);
            end
        end
    endtask

    // mode 0: out_ready held high; mode 1: out_ready toggles every cycle.
    task automatic drain(input int n, input int mode, input bit poke, input bit expect_first_valid);
        int         cnt = 0;
        int         cyc = 0;
        bit         first = 1'b1;
        bit         held_v = 1'b0;
        logic [7:0] held_data = 8'd0;
        logic       held_last = 1'b0;
        logic [7:0] e;
        while (cnt < n * n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (first && expect_first_valid) begin
                n_checks++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL latency: out_valid=%b required 1 two edges after last input", out_valid);
                end
            end
            first = 1'b0;
            if (held_v) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%b data=%0d last=%b required 1 %0d %b",
                             out_valid, $signed(out_data), out_last, $signed(held_data), held_last);
                end
                held_v = 1'b0;
            end
            out_ready = (mode == 1) ? cyc[0] : 1'b1;
            if (poke && out_valid) begin
                start = 1'b1;
                matrix_size = 2'b11;
            end
            if (out_valid) begin
                if (out_ready) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_output: data=%0d with empty scoreboard", $signed(out_data));
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data !== e) begin
                            n_fail++;
                            $display("FAIL data[%0d]: got %0d required %0d", cnt, $signed(out_data), $signed(e));
                        end
                    end
                    n_checks++;
                    if (out_last !== (cnt == n * n - 1)) begin
                        n_fail++;
                        $display("FAIL last[%0d]: got %b required %b", cnt, out_last, (cnt == n * n - 1));
                    end
                    cnt++;
                end else begin
                    held_v    = 1'b1;
                    held_data = out_data;
                    held_last = out_last;
                end
            end
        end
        n_checks++;
        if (cnt != n * n) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d outputs required %0d", cnt, n * n);
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b out_valid=%b busy=%b required 1 0 0", done, out_valid, busy);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: %0d expected elements never produced", exp_q.size());
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({in_ready, out_valid, out_last, busy, done} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: rdy/vld/last/busy/done=%b required 00000",
                     {in_ready, out_valid, out_last, busy, done});
        end
        n_checks++;
        if (out_data !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %0d required 0", out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b in_ready=%b required 0 0", busy, in_ready);
        end
    endtask

    task automatic test_2x2();
        for (int i = 0; i < 4; i++) stim[i] = 8'(i + 1);
        load_matrix(2, 1'b1, 0, 4);
        drain(2, 0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: done=%b required 0 one cycle later", done);
        end
    endtask

    task automatic test_3x3_latency();
        for (int i = 0; i < 9; i++) stim[i] = 8'(i + 1);
        load_matrix(3, 1'b1, 0, 9);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL calc_cycle: out_valid=%b busy=%b required 0 1", out_valid, busy);
        end
        drain(3, 0, 1'b0, 1'b1);
    endtask

    task automatic test_4x4_stall();
        for (int i = 0; i < 16; i++) stim[i] = 8'(-(i + 1));
        load_matrix(4, 1'b1, 0, 16);
        drain(4, 1, 1'b0, 1'b0);
    endtask

    task automatic test_5x5_gaps();
        for (int i = 0; i < 25; i++) stim[i] = (i % 2 == 1) ? 8'(-i) : 8'(i);
        load_matrix(5, 1'b1, 30, 25);
        drain(5, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL extra_valid: out_valid=%b required 0 after 25 outputs", out_valid);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 9; i++) stim[i] = 8'(i + 1);
        load_matrix(3, 1'b1, 0, 3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, out_last, busy, done} !== 5'b0 || out_data !== 8'd0) begin
            n_fail++;
            $display("FAIL abort_reset: flags=%b data=%0d required 00000 0",
                     {in_ready, out_valid, out_last, busy, done}, out_data);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) stim[i] = 8'(i + 1);
        load_matrix(2, 1'b1, 0, 4);
        drain(2, 0, 1'b0, 1'b0);
    endtask

    task automatic test_start_during_send();
        stim[0] = 8'd5; stim[1] = 8'd6; stim[2] = 8'd7; stim[3] = 8'd8;
        load_matrix(2, 1'b1, 0, 4);
        drain(2, 0, 1'b1, 1'b0);
        start = 1'b1;
        matrix_size = 2'b00;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_done: in_ready=%b busy=%b required 1 1", in_ready, busy);
        end
        stim[0] = 8'd10; stim[1] = 8'd20; stim[2] = 8'd30; stim[3] = 8'd40;
        load_matrix(2, 1'b0, 0, 4);
        drain(2, 0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_2x2();
        test_3x3_latency();
        test_4x4_stall();
        test_5x5_gaps();
        test_reset_mid_load();
        test_start_during_send();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
